// File: rtl/ce_acc_if.sv
// rtl/ce_acc_if.sv - beat input, config and result handshake bundle for ce_acc
interface ce_acc_if #(
    parameter int CH_PAR = 4,
    parameter int KERNEL = 3,
    parameter int N      = 8,
    parameter int M      = 8,
    parameter int B_W    = 16,
    parameter int OUT_W  = 16
);
    logic [CH_PAR*KERNEL*KERNEL*N-1:0] data2conv;
    logic [CH_PAR*KERNEL*KERNEL*M-1:0] w;
    logic                              en_in;
    logic                              in_ready;
    logic                              clr;
    logic                              relu_en;
    logic [4:0]                        sr;
    logic signed [B_W-1:0]             bias;
    logic signed [OUT_W-1:0]           d_out;
    logic                              en_out;
    logic                              out_ready;
    logic                              sat;

    modport slave (
        input  data2conv, w, en_in, clr, relu_en, sr, bias, out_ready,
        output in_ready, d_out, en_out, sat
    );

    modport master (
        output data2conv, w, en_in, clr, relu_en, sr, bias, out_ready,
        input  in_ready, d_out, en_out, sat
    );
endinterface

// File: rtl/ce_acc.sv
// rtl/ce_acc.sv - channel-serial convolution accumulator with bias, rounding shift, ReLU and saturation
module ce_acc #(
    parameter int CH_PAR = 4,
    parameter int KERNEL = 3,
    parameter int BEATS  = 4,
    parameter int N      = 8,
    parameter int M      = 8,
    parameter int B_W    = 16,
    parameter int OUT_W  = 16
) (
    input logic   clk,
    input logic   rst,
    ce_acc_if.slave io
);
    localparam int NP    = CH_PAR * KERNEL * KERNEL;
    localparam int ACC_W = N + M + $clog2(NP * BEATS) + 2;
    localparam int RW    = (ACC_W > OUT_W) ? ACC_W + 1 : OUT_W + 1;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
    localparam logic signed [OUT_W-1:0] OMAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] OMIN = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic signed [RW-1:0]    RMAX = RW'(OMAX);
    localparam logic signed [RW-1:0]    RMIN = RW'(OMIN);

    function automatic logic signed [ACC_W-1:0] mul_ext(
        input logic signed [N-1:0] a,
        input logic signed [M-1:0] b
    );
        logic signed [N+M-1:0] p;
        p = (N+M)'(a) * (N+M)'(b);
        return ACC_W'(p);
    endfunction

    logic [CNT_W-1:0]        cnt;
    logic signed [ACC_W-1:0] acc;
    logic                    relu_sh;
    logic [4:0]              sr_sh;
    logic signed [OUT_W-1:0] d_out_q;
    logic                    en_out_q;
    logic                    sat_q;

    logic                    first, last, accept, relu_eff;
    logic [4:0]              sr_eff;
    logic signed [ACC_W-1:0] psum, acc_next;
    logic signed [RW-1:0]    t_ext, rnd, r, r_relu;
    logic signed [OUT_W-1:0] d_res;
    logic                    sat_res;

    assign io.in_ready = !en_out_q || io.out_ready;
    assign io.d_out    = d_out_q;
    assign io.en_out   = en_out_q;
    assign io.sat      = sat_q;

    always_comb begin
        psum = '0;
        for (int i = 0; i < NP; i++) begin
            psum = psum + mul_ext(io.data2conv[i*N +: N], io.w[i*M +: M]);
        end
    end

    // Beat 0 takes its config straight from the ports; later beats use the shadows.
    always_comb begin
        first    = (cnt == '0);
        last     = (cnt == LAST);
        accept   = io.en_in && io.in_ready && !io.clr;
        acc_next = (first ? ACC_W'(io.bias) : acc) + psum;
        relu_eff = first ? io.relu_en : relu_sh;
        sr_eff   = first ? io.sr : sr_sh;
        t_ext    = RW'(acc_next);
        rnd      = (sr_eff == 5'd0) ? '0 : (RW'(1) << (sr_eff - 5'd1));
        r        = (t_ext + rnd) >>> sr_eff;
        r_relu   = (relu_eff && r < 0) ? '0 : r;
        sat_res  = 1'b0;
        d_res    = r_relu[OUT_W-1:0];
        if (r_relu > RMAX) begin
            d_res   = OMAX;
            sat_res = 1'b1;
        end else if (r_relu < RMIN) begin
            d_res   = OMIN;
            sat_res = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            acc      <= '0;
            relu_sh  <= 1'b0;
            sr_sh    <= '0;
            d_out_q  <= '0;
            en_out_q <= 1'b0;
            sat_q    <= 1'b0;
        end else begin
            if (io.clr) begin
                cnt <= '0;
                acc <= '0;
            end else if (accept) begin
                cnt <= last ? '0 : cnt + 1'b1;
                acc <= acc_next;
                if (first) begin
                    relu_sh <= io.relu_en;
                    sr_sh   <= io.sr;
                end
            end
            // A new final beat overrides the drain so back-to-back pixels leave no bubble.
            if (accept && last) begin
                d_out_q  <= d_res;
                sat_q    <= sat_res;
                en_out_q <= 1'b1;
            end else if (en_out_q && io.out_ready) begin
                en_out_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ce_acc.sv
// tb/tb_ce_acc.sv - scoreboard bench for ce_acc in a 1x1x1 and the default configuration
module tb_ce_acc;
    localparam int NPB = 36;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ce_acc_if #(.CH_PAR(1), .KERNEL(1)) ia();
    ce_acc_if ib();

    ce_acc #(.CH_PAR(1), .KERNEL(1), .BEATS(1)) dut_a (.clk(clk), .rst(rst), .io(ia));
    ce_acc dut_b (.clk(clk), .rst(rst), .io(ib));

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [16:0] qa[$];
    logic [16:0] qb[$];
    int hs_b[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic logic [16:0] model(input longint total, input longint bias, input int sr, input bit relu);
        longint t;
        bit s;
        s = 1'b0;
        t = total + bias;
        if (sr > 0) t = (t + (longint'(1) << (sr - 1))) >>> sr;
        if (relu && t < 0) t = 0;
        if (t > 32767) begin
            t = 32767; s = 1'b1;
        end else if (t < -32768) begin
            t = -32768; s = 1'b1;
        end
        return {s, t[15:0]};
    endfunction

    function automatic longint dot(input logic [NPB*8-1:0] dv, input logic [NPB*8-1:0] wv);
        longint s;
        logic signed [7:0] a, b;
        s = 0;
        for (int i = 0; i < NPB; i++) begin
            a = dv[i*8 +: 8];
            b = wv[i*8 +: 8];
            s += longint'(a) * longint'(b);
        end
        return s;
    endfunction

    function automatic logic [NPB*8-1:0] fill(input int v);
        logic [NPB*8-1:0] x;
        for (int i = 0; i < NPB; i++) x[i*8 +: 8] = 8'(v);
        return x;
    endfunction

    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst && ia.en_out && ia.out_ready) begin
            if (qa.size() == 0) begin
                n_checks++;
                $error("FAIL a_spurious observed=en_out expected=no_output");
            end else begin
                e = qa.pop_front();
                chk("a_d_out", ia.d_out, $signed(e[15:0]));
                chk("a_sat", ia.sat, e[16]);
            end
        end
    end

    always @(negedge clk) begin
        logic [16:0] e;
        if (!rst && ib.en_out && ib.out_ready) begin
            if (qb.size() == 0) begin
                n_checks++;
                $error("FAIL b_spurious observed=en_out expected=no_output");
            end else begin
                e = qb.pop_front();
                chk("b_d_out", ib.d_out, $signed(e[15:0]));
                chk("b_sat", ib.sat, e[16]);
                hs_b.push_back(cyc);
            end
        end
    end

    task automatic beat_b(input logic [NPB*8-1:0] dv, input logic [NPB*8-1:0] wv);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        ib.data2conv = dv;
        ib.w         = wv;
        ib.en_in     = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (ib.in_ready) done = 1'b1;
            @(posedge clk);
            #1;
            if (!done) begin
                n++;
                if (n > 100) begin
                    n_checks++;
                    $error("FAIL beat_timeout observed=stalled expected=accepted");
                    done = 1'b1;
                end
            end
        end
    endtask

    task automatic pixel_b(input int dval, input int wval, input int bval, input int srv, input bit relu, input bit rnd);
        logic [NPB*8-1:0] dv[4];
        logic [NPB*8-1:0] wv[4];
        longint total;
        total = 0;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < NPB; i++) begin
                dv[b][i*8 +: 8] = rnd ? 8'($urandom) : 8'(dval);
                wv[b][i*8 +: 8] = rnd ? 8'($urandom) : 8'(wval);
            end
            total += dot(dv[b], wv[b]);
        end
        qb.push_back(model(total, bval, srv, relu));
        for (int b = 0; b < 4; b++) begin
            if (b == 0) begin
                ib.bias    = 16'(bval);
                ib.sr      = 5'(srv);
                ib.relu_en = relu;
            end
            beat_b(dv[b], wv[b]);
            chk("b_latency", ib.en_out, b == 3);
            // Scramble config mid-pixel; the result must still use the beat-0 values.
            if (b == 0) begin
                ib.bias    = 16'($urandom);
                ib.sr      = 5'($urandom_range(0, 20));
                ib.relu_en = ~relu;
            end
        end
    endtask

    task automatic idle_b();
        ib.en_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        ia.data2conv = '0; ia.w = '0; ia.en_in = 1'b0; ia.clr = 1'b0;
        ia.relu_en = 1'b0; ia.sr = '0; ia.bias = '0; ia.out_ready = 1'b1;
        ib.data2conv = '0; ib.w = '0; ib.en_in = 1'b0; ib.clr = 1'b0;
        ib.relu_en = 1'b0; ib.sr = '0; ib.bias = '0; ib.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_b_en_out", ib.en_out, 0);
        chk("rst_b_d_out", ib.d_out, 0);
        chk("rst_b_sat", ib.sat, 0);
        chk("rst_a_en_out", ia.en_out, 0);
        rst = 1'b0;
        #1;
        chk("rst_b_in_ready", ib.in_ready, 1);

        ia.data2conv = 8'd3;
        ia.w         = 8'hFC;
        qa.push_back(model(-12, 0, 0, 0));
        ia.en_in = 1'b1;
        @(posedge clk);
        #1;
        chk("a_latency", ia.en_out, 1);
        ia.data2conv = 8'h80;
        ia.w         = 8'h80;
        ia.bias      = 16'sd16384;
        qa.push_back(model(16384, 16384, 0, 0));
        @(posedge clk);
        #1;
        ia.en_in = 1'b0;
        chk("a_latency2", ia.en_out, 1);
        @(posedge clk);
        #1;

        pixel_b(1, 1, 5, 0, 0, 0);   idle_b();
        pixel_b(1, 1, 5, 2, 0, 0);   idle_b();
        pixel_b(1, -1, 0, 2, 1, 0);  idle_b();
        pixel_b(1, -1, 0, 2, 0, 0);  idle_b();
        pixel_b(127, 127, 0, 0, 0, 0);
        pixel_b(127, -127, 0, 0, 0, 0);
        idle_b();

        ib.out_ready = 1'b0;
        pixel_b(2, 1, 3, 1, 0, 0);
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", ib.in_ready, 0);
            chk("stall_en_out", ib.en_out, 1);
            chk("stall_d_out", ib.d_out, 146);
        end
        @(posedge clk);
        #1;
        ib.out_ready = 1'b1;
        pixel_b(-3, 2, -7, 0, 0, 0);
        idle_b();

        hs_b.delete();
        for (int p = 0; p < 3; p++) begin
            pixel_b(0, 0, int'($urandom_range(0, 2000)) - 1000, int'($urandom_range(0, 6)),
                    1'($urandom_range(0, 1)), 1'b1);
        end
        idle_b();
        chk("tput_count", hs_b.size(), 3);
        if (hs_b.size() == 3) begin
            chk("tput_gap0", hs_b[1] - hs_b[0], 4);
            chk("tput_gap1", hs_b[2] - hs_b[1], 4);
        end

        ib.bias = 16'sd7; ib.sr = '0; ib.relu_en = 1'b0;
        beat_b(fill(5), fill(3));
        beat_b(fill(5), fill(3));
        ib.clr = 1'b1;
        @(posedge clk);
        #1;
        ib.clr = 1'b0;
        idle_b();
        pixel_b(1, 1, 0, 0, 0, 0);
        idle_b();

        ib.out_ready = 1'b0;
        ib.bias = '0; ib.sr = '0; ib.relu_en = 1'b0;
        for (int b = 0; b < 4; b++) beat_b(fill(1), fill(2));
        chk("pend_en_out", ib.en_out, 1);
        ib.en_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_en_out", ib.en_out, 0);
        chk("arst_d_out", ib.d_out, 0);
        chk("arst_sat", ib.sat, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ib.out_ready = 1'b1;
        ib.bias = 16'sd100;
        beat_b(fill(9), fill(9));
        beat_b(fill(9), fill(9));
        ib.en_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst2_en_out", ib.en_out, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pixel_b(1, 3, -20, 1, 0, 0);
        idle_b();
        idle_b();

        chk("sb_a_empty", qa.size(), 0);
        chk("sb_b_empty", qb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
